fetch_unit: RTL and testbench

- PC/fetch stage directly upstream of the instruction memory; drives its 6-bit word address every cycle.
- Holds the architectural PC and computes next PC: sequential, branch, exception vector or ERET return.
- Contains the exception-entry state machine: saves ELR/ESR, inserts one bubble on entry, detects double faults.
- Single-cycle datapath; only PC, ELR, ESR and FSM state are registered.

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Handshake/bus bundle between the fetch stage and its surroundings:
// control inputs from the pipeline, and PC/exception state outputs.
interface fetch_unit_if #(
  parameter int N = 64
);
  logic         stall;
  logic         br_taken;
  logic [N-1:0] branch_target;
  logic         exc_req;
  logic [3:0]   exc_code;
  logic         eret;
  logic [N-1:0] pc;
  logic [5:0]   imem_addr;
  logic         fetch_valid;
  logic [N-1:0] elr;
  logic [3:0]   esr;
  logic         in_handler;
  logic         halted;

  modport master (
    output stall, br_taken, branch_target, exc_req, exc_code, eret,
    input  pc, imem_addr, fetch_valid, elr, esr, in_handler, halted
  );

  modport slave (
    input  stall, br_taken, branch_target, exc_req, exc_code, eret,
    output pc, imem_addr, fetch_valid, elr, esr, in_handler, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// PC/fetch stage: next-PC selection plus the exception-entry FSM
// (ELR/ESR capture, one-cycle entry bubble, double-fault halt).
module fetch_unit #(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter logic [N-1:0] VECTOR   = N'('hD8)
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_unit_if.slave   bus
);

  typedef enum logic [1:0] {RUN, ENTRY, HANDLER, HALT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] elr_q, elr_d;
  logic [3:0]   esr_q, esr_d;

  logic         misalign;
  logic         exc_eff;
  logic [3:0]   cause;
  logic [N-1:0] pc_seq;

  // A taken branch to a non-word-aligned target faults with cause F,
  // but an explicit exception request in the same cycle takes precedence.
  assign misalign = bus.br_taken && (bus.branch_target[1:0] != 2'b00);
  assign exc_eff  = bus.exc_req || misalign;
  assign cause    = bus.exc_req ? bus.exc_code : 4'hF;
  assign pc_seq   = pc_q + N'(4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      elr_q   <= '0;
      esr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      elr_q   <= elr_d;
      esr_q   <= esr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    elr_d   = elr_q;
    esr_d   = esr_q;
    case (state_q)
      RUN: begin
        if (exc_eff) begin
          elr_d   = pc_q;
          esr_d   = cause;
          pc_d    = VECTOR;
          state_d = ENTRY;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.br_taken) begin
          pc_d = bus.branch_target;
        end else begin
          pc_d = pc_seq;
        end
      end
      ENTRY: begin
        state_d = HANDLER;
      end
      HANDLER: begin
        // A fault inside the handler is a double fault: freeze everything.
        if (exc_eff) begin
          state_d = HALT;
        end else if (bus.eret) begin
          pc_d    = elr_q + N'(4);
          state_d = RUN;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.br_taken) begin
          pc_d = bus.branch_target;
        end else begin
          pc_d = pc_seq;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
        pc_d    = RESET_PC;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.imem_addr   = pc_q[7:2];
  assign bus.fetch_valid = (state_q != ENTRY) && (state_q != HALT);
  assign bus.elr         = elr_q;
  assign bus.esr         = esr_q;
  assign bus.in_handler  = (state_q == HANDLER);
  assign bus.halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequencing, branches, exception entry/return,
// misaligned branches, double-fault halt and asynchronous reset.
module tb_fetch_unit;
  localparam int N = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.N(N)) bus ();

  fetch_unit #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall         = 1'b0;
    bus.br_taken      = 1'b0;
    bus.branch_target = '0;
    bus.exc_req       = 1'b0;
    bus.exc_code      = 4'h0;
    bus.eret          = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    chk("rst_pc", bus.pc, 64'h0);
    chk("rst_elr", bus.elr, 64'h0);
    chk("rst_esr", 64'(bus.esr), 64'h0);
    chk("rst_inh", 64'(bus.in_handler), 64'h0);
    chk("rst_halt", 64'(bus.halted), 64'h0);
    reset_n = 1'b1;
    chk("rst_fv", 64'(bus.fetch_valid), 64'h1);

    // Free-running sequence 0,4,8,12,16
    for (int i = 0; i < 5; i++) begin
      chk("seq_pc", bus.pc, 64'(4 * i));
      chk("seq_ia", 64'(bus.imem_addr), 64'(i));
      chk("seq_fv", 64'(bus.fetch_valid), 64'h1);
      if (i < 4) step();
    end

    // Stall beats branch, then branch alone
    bus.stall = 1'b1; bus.br_taken = 1'b1; bus.branch_target = 64'h40;
    step();
    chk("stall_br_pc", bus.pc, 64'h10);
    bus.stall = 1'b0;
    step();
    chk("br_pc", bus.pc, 64'h40);
    chk("br_ia", 64'(bus.imem_addr), 64'd16);

    // Branch to 0x20 then raise exception code 3
    bus.branch_target = 64'h20;
    step();
    chk("br20_pc", bus.pc, 64'h20);
    bus.br_taken = 1'b0;
    bus.exc_req = 1'b1; bus.exc_code = 4'h3;
    step();
    chk("exc_pc", bus.pc, 64'hD8);
    chk("exc_elr", bus.elr, 64'h20);
    chk("exc_esr", 64'(bus.esr), 64'h3);
    chk("exc_fv", 64'(bus.fetch_valid), 64'h0);
    chk("exc_inh", 64'(bus.in_handler), 64'h0);
    bus.exc_req = 1'b0; bus.exc_code = 4'h0;
    step();
    chk("hnd0_pc", bus.pc, 64'hD8);
    chk("hnd0_inh", 64'(bus.in_handler), 64'h1);
    chk("hnd0_fv", 64'(bus.fetch_valid), 64'h1);
    step();
    chk("hnd1_pc", bus.pc, 64'hDC);
    bus.eret = 1'b1;
    step();
    chk("eret_pc", bus.pc, 64'h24);
    chk("eret_inh", 64'(bus.in_handler), 64'h0);

    // eret in RUN is ignored
    step();
    chk("eret_run_pc", bus.pc, 64'h28);
    chk("eret_run_inh", 64'(bus.in_handler), 64'h0);
    bus.eret = 1'b0;

    // Misaligned branch target faults with cause F
    bus.br_taken = 1'b1; bus.branch_target = 64'h42;
    step();
    chk("mis_pc", bus.pc, 64'hD8);
    chk("mis_elr", bus.elr, 64'h28);
    chk("mis_esr", 64'(bus.esr), 64'hF);
    chk("mis_fv", 64'(bus.fetch_valid), 64'h0);
    bus.br_taken = 1'b0; bus.branch_target = '0;
    step();
    chk("mis_inh", 64'(bus.in_handler), 64'h1);

    // Exception together with eret inside handler -> double fault
    bus.exc_req = 1'b1; bus.exc_code = 4'h7; bus.eret = 1'b1;
    step();
    chk("dbl_halt", 64'(bus.halted), 64'h1);
    chk("dbl_fv", 64'(bus.fetch_valid), 64'h0);
    chk("dbl_pc", bus.pc, 64'hD8);
    chk("dbl_elr", bus.elr, 64'h28);
    chk("dbl_esr", 64'(bus.esr), 64'hF);
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin bus.br_taken = 1'b1; bus.branch_target = 64'h80; end
      step();
      chk("halt_pc", bus.pc, 64'hD8);
      chk("halt_flag", 64'(bus.halted), 64'h1);
    end
    idle_inputs();

    // Reset pulse leaves HALT
    reset_n = 1'b0;
    #2;
    chk("rp_pc", bus.pc, 64'h0);
    chk("rp_halt", 64'(bus.halted), 64'h0);
    reset_n = 1'b1;
    step();
    chk("rp_next_pc", bus.pc, 64'h4);
    chk("rp_fv", 64'(bus.fetch_valid), 64'h1);

    // Address wrap: imem_addr modulo 64 words, pc+4 modulo 2^N
    bus.br_taken = 1'b1; bus.branch_target = 64'h100;
    step();
    chk("wrap_ia0", 64'(bus.imem_addr), 64'h0);
    bus.branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    chk("wrap_ia3f", 64'(bus.imem_addr), 64'h3F);
    bus.br_taken = 1'b0; bus.branch_target = '0;
    step();
    chk("wrap_pc", bus.pc, 64'h0);

    // Asynchronous reset in the middle of ENTRY
    bus.exc_req = 1'b1; bus.exc_code = 4'h5;
    step();
    chk("ent_fv", 64'(bus.fetch_valid), 64'h0);
    chk("ent_esr", 64'(bus.esr), 64'h5);
    bus.exc_req = 1'b0; bus.exc_code = 4'h0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_pc", bus.pc, 64'h0);
    chk("async_elr", bus.elr, 64'h0);
    chk("async_esr", 64'(bus.esr), 64'h0);
    chk("async_fv", 64'(bus.fetch_valid), 64'h1);
    chk("async_inh", 64'(bus.in_handler), 64'h0);
    #1;
    reset_n = 1'b1;
    step();
    chk("async_next_pc", bus.pc, 64'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
